// File: rtl/instr_encoder_loader.sv
// Packs one instruction's discrete fields into a 32-bit word and writes it to
// instruction memory, one word per valid/ready tuple, until the last one lands.
module instr_encoder_loader #(
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic              in_i,
  input  logic              in_l,
  input  logic [3:0]        in_cmd,
  input  logic [3:0]        in_cond,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [23:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err_illegal,
  output logic              err_range,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        illegal;
  logic        range_bad;
  logic        last_q;
  logic [31:0] enc;

  assign full     = (word_count == FULL_COUNT);
  assign in_ready = (state == S_READY) && !full;
  assign accept   = in_valid && in_ready;
  assign illegal  = (in_op == 2'b11);
  assign mem_we   = (state == S_WRITE);
  assign busy     = (state == S_READY) || (state == S_WRITE);
  assign done     = (state == S_DONE);

  always_comb begin
    enc        = '0;
    range_bad  = 1'b0;
    enc[31:28] = in_cond;
    enc[27:26] = in_op;
    case (in_op)
      2'b00: begin
        enc[25]    = in_i;
        enc[24:21] = in_cmd;
        enc[19:16] = in_rn;
        enc[15:12] = in_rd;
        enc[11:0]  = in_i ? {4'b0, in_imm[7:0]} : {8'b0, in_rm};
        range_bad  = in_i && (|in_imm[23:8]);
      end
      2'b01: begin
        enc[24:21] = 4'b1100;
        enc[20]    = in_l;
        enc[19:16] = in_rn;
        enc[15:12] = in_rd;
        enc[11:0]  = in_imm[11:0];
        range_bad  = |in_imm[23:12];
      end
      2'b10: begin
        enc[25]   = 1'b1;
        enc[24]   = in_l;
        enc[23:0] = in_imm;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // start overrides every state, including abandoning a write in flight
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  ;
      S_READY: begin
        if (accept) begin
          if (!illegal)     state_nxt = S_WRITE;
          else if (in_last) state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (mem_ack) state_nxt = last_q ? S_DONE : S_READY;
      end
      S_DONE:  ;
      default: state_nxt = S_IDLE;
    endcase
    if (start) state_nxt = S_READY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr    <= BASE;
      word_count  <= '0;
      mem_wdata   <= '0;
      last_q      <= 1'b0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else if (start) begin
      mem_addr    <= BASE;
      word_count  <= '0;
      last_q      <= 1'b0;
      err_illegal <= 1'b0;
      err_range   <= 1'b0;
    end else begin
      if (accept) begin
        if (illegal) begin
          err_illegal <= 1'b1;
        end else begin
          mem_wdata <= enc;
          last_q    <= in_last;
          if (range_bad) err_range <= 1'b1;
        end
      end
      if (mem_we && mem_ack) begin
        mem_addr   <= mem_addr + ADDR_W'(1);
        word_count <= word_count + (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: table of field tuples with expected words, a memory
// responder that pops a scoreboard on every ack, plus fill and reset sequences.
module tb_instr_encoder_loader;

  typedef struct {
    logic [1:0]  op;
    logic        i;
    logic        l;
    logic [3:0]  cmd;
    logic [3:0]  cond;
    logic [3:0]  rd;
    logic [3:0]  rn;
    logic [3:0]  rm;
    logic [23:0] imm;
    logic        last;
    logic        wr;
    logic [31:0] word;
    logic        ill;
    logic        rng;
  } vec_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic        in_i;
  logic        in_l;
  logic [3:0]  in_cmd;
  logic [3:0]  in_cond;
  logic [3:0]  in_rd;
  logic [3:0]  in_rn;
  logic [3:0]  in_rm;
  logic [23:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        full;
  logic        err_illegal;
  logic        err_range;
  logic [6:0]  word_count;

  int   compared   = 0;
  int   mismatched = 0;
  int   ack_delay  = 1;
  int   we_cycles  = 0;
  exp_t sbq[$];
  vec_t vecs[8];
  int   exp_cnt;
  logic exp_ill;
  logic exp_rng;

  instr_encoder_loader #(.ADDR_W(6), .DEPTH(64), .BASE_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_i(in_i), .in_l(in_l), .in_cmd(in_cmd), .in_cond(in_cond),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .full(full), .err_illegal(err_illegal),
    .err_range(err_range), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: acknowledges after ack_delay cycles of mem_we and scores the write
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_we === 1'b1) begin
      we_cycles++;
      if (we_cycles >= ack_delay) begin
        mem_ack   = 1'b1;
        we_cycles = 0;
        if (sbq.size() == 0) begin
          checkOutput("unexpected_write", {32'h0, mem_wdata}, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("wr_addr", 64'(mem_addr), 64'(e.addr));
          checkOutput("wr_data", 64'(mem_wdata), 64'(e.data));
        end
      end
    end else begin
      we_cycles = 0;
    end
  end

  function automatic vec_t mkVec(
      input logic [1:0] op, input logic i, input logic l, input logic [3:0] cmd,
      input logic [3:0] cond, input logic [3:0] rd, input logic [3:0] rn,
      input logic [3:0] rm, input logic [23:0] imm, input logic last,
      input logic wr, input logic [31:0] word, input logic ill, input logic rng);
    vec_t v;
    v.op = op; v.i = i; v.l = l; v.cmd = cmd; v.cond = cond; v.rd = rd;
    v.rn = rn; v.rm = rm; v.imm = imm; v.last = last; v.wr = wr;
    v.word = word; v.ill = ill; v.rng = rng;
    return v;
  endfunction

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_cnt = 0;
    exp_ill = 1'b0;
    exp_rng = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    int waitc = 0;
    in_op = v.op; in_i = v.i; in_l = v.l; in_cmd = v.cmd; in_cond = v.cond;
    in_rd = v.rd; in_rn = v.rn; in_rm = v.rm; in_imm = v.imm; in_last = v.last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (in_ready !== 1'b1) begin
      checkOutput("ready_timeout", 64'(in_ready), 64'd1);
    end else if (v.wr) begin
      sbq.push_back({6'(exp_cnt % 64), v.word});
      exp_cnt++;
    end
    exp_ill = exp_ill | v.ill;
    exp_rng = exp_rng | v.rng;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drainWrites();
    int waitc = 0;
    while ((sbq.size() != 0 || mem_we === 1'b1) && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    checkOutput("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = mkVec(2'b00, 1, 0, 4'h4, 4'hE, 4'h2, 4'h1, 4'h0, 24'h000005, 0, 1, 32'hE281_2005, 0, 0);
    vecs[1] = mkVec(2'b01, 0, 1, 4'h0, 4'hE, 4'h4, 4'h3, 4'h0, 24'h000010, 0, 1, 32'hE593_4010, 0, 0);
    vecs[2] = mkVec(2'b01, 0, 0, 4'h0, 4'hE, 4'h4, 4'h3, 4'h0, 24'h000010, 0, 1, 32'hE583_4010, 0, 0);
    vecs[3] = mkVec(2'b00, 0, 0, 4'h2, 4'h0, 4'h6, 4'h5, 4'h7, 24'hFFFF00, 0, 1, 32'h0045_6007, 0, 0);
    vecs[4] = mkVec(2'b11, 0, 0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 24'h000000, 0, 0, 32'h0000_0000, 1, 0);
    vecs[5] = mkVec(2'b00, 1, 0, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 24'h0001FF, 0, 1, 32'hE200_00FF, 0, 1);
    vecs[6] = mkVec(2'b01, 0, 0, 4'h0, 4'hE, 4'h1, 4'h2, 4'h0, 24'h001ABC, 0, 1, 32'hE582_1ABC, 0, 1);
    vecs[7] = mkVec(2'b10, 0, 1, 4'h0, 4'hE, 4'h0, 4'h0, 4'h0, 24'h000004, 1, 1, 32'hEB00_0004, 0, 0);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_op = '0; in_i = 0; in_l = 0;
    in_cmd = '0; in_cond = '0; in_rd = '0; in_rn = '0; in_rm = '0; in_imm = '0; in_last = 0;
    exp_cnt = 0; exp_ill = 0; exp_rng = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_count", 64'(word_count), 64'd0);
    checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", 64'(in_ready), 64'd0);

    doStart();
    checkOutput("start_busy", 64'(busy), 64'd1);
    checkOutput("start_in_ready", 64'(in_ready), 64'd1);
    ack_delay = 1;
    for (int n = 0; n < 8; n++) begin
      applyStimulus(vecs[n]);
      drainWrites();
      checkOutput($sformatf("v%0d_count", n), 64'(word_count), 64'(exp_cnt));
      checkOutput($sformatf("v%0d_addr", n), 64'(mem_addr), 64'(exp_cnt % 64));
      checkOutput($sformatf("v%0d_err_ill", n), 64'(err_illegal), 64'(exp_ill));
      checkOutput($sformatf("v%0d_err_rng", n), 64'(err_range), 64'(exp_rng));
    end
    checkOutput("prog_done", 64'(done), 64'd1);
    checkOutput("prog_busy", 64'(busy), 64'd0);
    checkOutput("prog_in_ready", 64'(in_ready), 64'd0);

    doStart();
    checkOutput("restart_done", 64'(done), 64'd0);
    checkOutput("restart_count", 64'(word_count), 64'd0);
    checkOutput("restart_err_ill", 64'(err_illegal), 64'd0);
    checkOutput("restart_err_rng", 64'(err_range), 64'd0);

    // Fill all DEPTH words with a slow memory, then confirm further tuples are ignored
    ack_delay = 3;
    for (int k = 0; k < 64; k++) begin
      vec_t v;
      v = mkVec(2'b00, 1, 0, 4'h0, 4'hE, 4'(k % 16), 4'h0, 4'h0, 24'(k), 0, 1,
                32'hE200_0000 | (32'(k % 16) << 12) | 32'(k), 0, 0);
      applyStimulus(v);
    end
    drainWrites();
    checkOutput("fill_full", 64'(full), 64'd1);
    checkOutput("fill_count", 64'(word_count), 64'd64);
    checkOutput("fill_addr_wrap", 64'(mem_addr), 64'd0);
    checkOutput("fill_in_ready", 64'(in_ready), 64'd0);
    in_op = 2'b00; in_i = 1'b1; in_imm = 24'h42; in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("full_ignored_count", 64'(word_count), 64'd64);
    checkOutput("full_no_we", 64'(mem_we), 64'd0);
    checkOutput("full_done", 64'(done), 64'd0);

    // Async reset while a write is pending
    doStart();
    ack_delay = 1;
    applyStimulus(vecs[0]);
    drainWrites();
    ack_delay = 20;
    applyStimulus(vecs[1]);
    @(negedge clk);
    checkOutput("pre_rst_we", 64'(mem_we), 64'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_rst_we", 64'(mem_we), 64'd0);
    checkOutput("async_rst_addr", 64'(mem_addr), 64'd0);
    checkOutput("async_rst_count", 64'(word_count), 64'd0);
    checkOutput("async_rst_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("async_rst_busy", 64'(busy), 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'd0);
    checkOutput("post_rst_no_we", 64'(mem_we), 64'd0);
    checkOutput("post_rst_count", 64'(word_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
